// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-port bus between the initiator (CPU) and the
// data-memory responder.
//   mem_cen    request valid, held stable by the CPU while mem_stall=1
//   mem_wen    1 = write, 0 = read
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_rdata  read data, valid in the response cycle
//   mem_stall  CPU must hold the request and freeze
// Modports: master = CPU side, slave = memory side.
interface dmem_responder_if #(
    parameter int DW = 32
) ();
    logic          mem_cen;
    logic          mem_wen;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall;

    modport master (
        output mem_cen, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall
    );

    modport slave (
        input  mem_cen, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_stall
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM answering CPU requests with a
// programmable number of wait states.
//   clk, rst   single clock, synchronous active-high reset
//   bus        dmem_responder_if.slave (cen/wen/addr/wdata in, rdata/stall out)
//   err        sticky flags: [0] misaligned, [1] out-of-range,
//              [2] request changed while stalled
//   dbg_addr   backdoor word index
//   dbg_rdata  combinational RAM[dbg_addr], no side effects
// An access takes LATENCY+1 cycles: LATENCY stalled cycles (IDLE accept plus
// LATENCY-1 WAIT cycles) followed by one RESP cycle. LATENCY must be 1..15.
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 5,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_responder_if.slave       bus,
    output logic [2:0]            err,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DW-1:0]         dbg_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          req_wen;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    logic          accept;
    logic          commit;
    logic          changed;
    logic          eff_wen;
    logic [AW-1:0] eff_idx;
    logic [DW-1:0] eff_wdata;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        changed   = 1'b0;
        // The latched copy is what executes; only when LATENCY=1 does the
        // commit edge coincide with the accept edge, so the bus is used then.
        eff_wen   = req_wen;
        eff_idx   = req_addr[AW+1:2];
        eff_wdata = req_wdata;
        case (state)
            IDLE: begin
                eff_wen   = bus.mem_wen;
                eff_idx   = bus.mem_addr[AW+1:2];
                eff_wdata = bus.mem_wdata;
                if (bus.mem_cen) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end
                end
            end
            WAIT: begin
                changed = !bus.mem_cen
                        || (bus.mem_wen   != req_wen)
                        || (bus.mem_addr  != req_addr)
                        || (bus.mem_wdata != req_wdata);
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset wins over a commit landing on the same edge.
        if (rst) commit = 1'b0;
    end

    assign bus.mem_stall = !rst && ((state == IDLE && bus.mem_cen) || state == WAIT);
    assign bus.mem_rdata = rdata_q;
    assign dbg_rdata     = ram[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= '0;
            err     <= 3'b000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= 4'(LATENCY - 1);
                err[0] <= err[0] | (|bus.mem_addr[1:0]);
                err[1] <= err[1] | (|bus.mem_addr[31:AW+2]);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (changed) err[2] <= 1'b1;
            // Read-before-write: a write also returns the old word.
            if (commit) rdata_q <= ram[eff_idx];
        end
    end

    // Request register: only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            req_wen   <= bus.mem_wen;
            req_addr  <= bus.mem_addr;
            req_wdata <= bus.mem_wdata;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && eff_wen) ram[eff_idx] <= eff_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against
// a word-array reference model of the memory and its sticky error flags.
module tb_dmem_responder;
    localparam int L     = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    err;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;

    always #5 clk = ~clk;

    dmem_responder_if #(.DW(DW)) bus ();

    dmem_responder #(.LATENCY(L), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err       (err),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic [2:0]  err_m;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access, entered just after a clock edge with the DUT idle.
    // Leaves cen high unless drop is set, so a following call is back-to-back.
    task automatic access(input bit wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit drop);
        int          idx   = int'((addr >> 2) % DEPTH);
        logic [31:0] exp_rd = ref_mem[idx];
        bit          known = ref_known[idx];
        if (addr % 4 != 0)     err_m[0] = 1'b1;
        if (addr >= 4 * DEPTH) err_m[1] = 1'b1;
        if (wen) begin
            ref_mem[idx]   = wdata;
            ref_known[idx] = 1'b1;
        end
        bus.mem_cen   = 1'b1;
        bus.mem_wen   = wen;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            check("stall", 32'(bus.mem_stall), 32'(c < L));
            if (c == L) begin
                if (known) check("rdata", bus.mem_rdata, exp_rd);
                check("err", 32'(err), 32'(err_m));
                last_rd = exp_rd;
            end
            @(posedge clk);
            #1;
        end
        if (drop) bus.mem_cen = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        err_m         = 3'b000;
        last_rd       = '0;
        dbg_addr      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        // Reset with cen high: stall must stay low while rst=1.
        rst           = 1'b1;
        bus.mem_cen   = 1'b1;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(bus.mem_stall), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_cen = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("idle_stall", 32'(bus.mem_stall), 32'd0);
        @(posedge clk);
        #1;

        // Preload every word so the model is fully known.
        for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 1'b1);
        access(1'b1, 32'd12, 32'hDEADBEEF, 1'b1);

        // Read idx 3, then rdata must hold across idle cycles.
        access(1'b0, 32'd12, 32'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rdata_hold", bus.mem_rdata, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;

        // Write then read 0x10; write returns the old word.
        access(1'b1, 32'h10, 32'h12345678, 1'b1);
        dbg_addr = 5'd4;
        #1;
        check("dbg_after_wr", dbg_rdata, 32'h12345678);
        access(1'b0, 32'h10, 32'd0, 1'b1);

        // Back-to-back reads with cen held high.
        access(1'b0, 32'd12, 32'd0, 1'b0);
        access(1'b0, 32'h10, 32'd0, 1'b0);
        access(1'b0, 32'd12, 32'd0, 1'b1);

        // Misaligned + out-of-range read aliases to idx 1.
        access(1'b0, 32'h86, 32'd0, 1'b1);
        check("err_011", 32'(err), 32'd3);

        // Write data changes during WAIT: original data commits, err[2] set.
        bus.mem_cen   = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = 32'h08;
        bus.mem_wdata = 32'd1;
        @(negedge clk);
        check("chg_stall0", 32'(bus.mem_stall), 32'd1);
        @(posedge clk);
        #1;
        bus.mem_wdata = 32'd2;
        @(negedge clk);
        check("chg_stall1", 32'(bus.mem_stall), 32'd1);
        @(posedge clk);
        #1;
        err_m[2]   = 1'b1;
        ref_mem[2] = 32'd1;
        @(negedge clk);
        check("chg_stall2", 32'(bus.mem_stall), 32'd0);
        check("chg_err", 32'(err), 32'(err_m));
        @(posedge clk);
        #1;
        bus.mem_cen = 1'b0;
        dbg_addr    = 5'd2;
        #1;
        check("chg_ram2", dbg_rdata, 32'd1);

        // Reset on the commit edge of a write: the write must not land.
        access(1'b1, 32'd28, 32'h55, 1'b1);
        bus.mem_cen   = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = 32'd28;
        bus.mem_wdata = 32'hAA;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.mem_cen = 1'b0;
        @(negedge clk);
        check("rstw_stall_in", 32'(bus.mem_stall), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        err_m = 3'b000;
        dbg_addr = 5'd7;
        @(negedge clk);
        check("rstw_stall", 32'(bus.mem_stall), 32'd0);
        check("rstw_err", 32'(err), 32'd0);
        check("rstw_rdata", bus.mem_rdata, 32'd0);
        check("rstw_ram7", dbg_rdata, 32'h55);
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom % 8 == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom % 8 == 0) a = a | (32'h100 << $urandom_range(0, 20));
            access(1'($urandom), a, $urandom, 1'($urandom));
        end
        bus.mem_cen = 1'b0;
        @(posedge clk);
        #1;

        // Backdoor sweep of the whole RAM.
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = AW'(i);
            #1;
            check("dbg_sweep", dbg_rdata, ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
